// File: rtl/cnt1_stream_pkg.sv
// Shared sizing helpers for the cnt1 popcount family: word count, tail width,
// adder-tree depth and pipeline latency derived from the vector/bus geometry.
package cnt1_stream_pkg;

  localparam int DEF_VECTOR_WIDTH  = 920;
  localparam int DEF_BUS_WIDTH     = 128;
  localparam int DEF_GRANULE_WIDTH = 6;

  typedef struct packed {
    logic first;
    logic last;
  } word_tag_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog3(input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < n) begin
      p = p * 3;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int sub_vector_no(input int vw, input int bw);
    return ceil_div(vw, bw);
  endfunction

  function automatic int tail_bits(input int vw, input int bw);
    return vw - (sub_vector_no(vw, bw) - 1) * bw;
  endfunction

  // Granules are pre-summed in threes, so the tree only spans the resulting groups.
  function automatic int tree_levels(input int bw, input int gw);
    return clog3(ceil_div(bw, 3 * gw));
  endfunction

  function automatic int latency(input int bw, input int gw);
    return tree_levels(bw, gw) + 2;
  endfunction

endpackage

// File: rtl/cnt1_stream_popcnt_pipe.sv
// Pipelined popcount: granule LUT counts summed in threes, then a registered
// ternary adder tree. Latency is tree_levels+1 enabled cycles.
module cnt1_stream_popcnt_pipe
  import cnt1_stream_pkg::*;
#(
  parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int GRANULE_WIDTH = DEF_GRANULE_WIDTH,
  parameter int SUM_WIDTH     = $clog2(BUS_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [BUS_WIDTH-1:0] vec_i,
  output logic [SUM_WIDTH-1:0] sum_o
);

  localparam int GRP_W  = 3 * GRANULE_WIDTH;
  localparam int NG1    = ceil_div(BUS_WIDTH, GRP_W);
  localparam int NGR    = 3 * NG1;
  localparam int PAD_W  = NGR * GRANULE_WIDTH;
  localparam int LEVELS = tree_levels(BUS_WIDTH, GRANULE_WIDTH);
  localparam int NODES  = 3 * NG1;

  logic [PAD_W-1:0]     vec_pad;
  logic [SUM_WIDTH-1:0] gran_cnt [NGR];
  logic [SUM_WIDTH-1:0] node_d   [LEVELS+1][NODES];
  logic [SUM_WIDTH-1:0] node_q   [LEVELS+1][NODES];

  assign vec_pad = PAD_W'(vec_i);

  for (genvar gi = 0; gi < NGR; gi++) begin : g_gran
    assign gran_cnt[gi] = SUM_WIDTH'($countones(vec_pad[gi*GRANULE_WIDTH +: GRANULE_WIDTH]));
  end

  // Unused node slots stay zero, so every ternary add may read a full triple.
  always_comb begin
    node_d = '{default: '0};
    for (int k = 0; k < NG1; k++) begin
      node_d[0][k] = gran_cnt[3*k] + gran_cnt[3*k+1] + gran_cnt[3*k+2];
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int k = 0; k < NG1; k++) begin
        node_d[l][k] = node_q[l-1][3*k] + node_q[l-1][3*k+1] + node_q[l-1][3*k+2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      node_q <= node_d;
    end
  end

  assign sum_o = node_q[LEVELS][0];

endmodule

// File: rtl/cnt1_stream.sv
// Streaming popcount over multi-word vectors with valid/ready backpressure,
// tail-bit masking and a running per-vector count on every output word.
module cnt1_stream
  import cnt1_stream_pkg::*;
#(
  parameter int VECTOR_WIDTH  = DEF_VECTOR_WIDTH,
  parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int GRANULE_WIDTH = DEF_GRANULE_WIDTH,
  parameter bit MASK_TAIL     = 1'b1,
  parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_Flush,
  input  logic [BUS_WIDTH-1:0] i_Vector,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  output logic [BUS_WIDTH-1:0] o_SubVector,
  output logic                 o_Valid,
  output logic                 o_Last,
  output logic [CNT_WIDTH-1:0] o_Cnt,
  output logic                 o_CntNew,
  input  logic                 i_Ready
);

  localparam int SUB_VECTOR_NO = sub_vector_no(VECTOR_WIDTH, BUS_WIDTH);
  localparam int TAIL_BITS     = tail_bits(VECTOR_WIDTH, BUS_WIDTH);
  localparam int LATENCY       = latency(BUS_WIDTH, GRANULE_WIDTH);
  localparam int PIPE_LAT      = LATENCY - 1;
  localparam int LAST_STG      = PIPE_LAT - 1;
  localparam int SUM_WIDTH     = $clog2(BUS_WIDTH + 1);
  localparam int WC_W          = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam logic [BUS_WIDTH-1:0] TAIL_MASK = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - TAIL_BITS);

  logic                 en;
  logic                 accept;
  logic [WC_W-1:0]      wcnt_q;
  logic [WC_W-1:0]      wcnt_d;
  word_tag_t            in_tag;
  logic [BUS_WIDTH-1:0] in_word;
  logic [SUM_WIDTH-1:0] pipe_sum;

  logic                 dl_valid_q [PIPE_LAT];
  word_tag_t            dl_tag_q   [PIPE_LAT];
  logic [BUS_WIDTH-1:0] dl_data_q  [PIPE_LAT];

  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 out_cntnew_q;
  logic [BUS_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0] acc_q;

  assign en      = i_Ready | ~out_valid_q;
  assign o_Ready = en & ~rst & ~i_Flush;
  assign accept  = i_Valid & o_Ready;

  assign in_tag.first = (wcnt_q == '0);
  assign in_tag.last  = (wcnt_q == WC_W'(SUB_VECTOR_NO - 1));
  assign in_word      = (MASK_TAIL && in_tag.last) ? (i_Vector & TAIL_MASK) : i_Vector;

  always_comb begin
    wcnt_d = wcnt_q;
    if (accept) begin
      wcnt_d = in_tag.last ? '0 : wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_Flush) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  cnt1_stream_popcnt_pipe #(
    .BUS_WIDTH     (BUS_WIDTH),
    .GRANULE_WIDTH (GRANULE_WIDTH),
    .SUM_WIDTH     (SUM_WIDTH)
  ) u_popcnt (
    .clk   (clk),
    .en_i  (en),
    .vec_i (in_word),
    .sum_o (pipe_sum)
  );

  // Word and flags ride alongside the adder tree so they line up with its sum.
  always_ff @(posedge clk) begin
    if (rst || i_Flush) begin
      for (int k = 0; k < PIPE_LAT; k++) dl_valid_q[k] <= 1'b0;
    end else if (en) begin
      dl_valid_q[0] <= accept;
      for (int k = 1; k < PIPE_LAT; k++) dl_valid_q[k] <= dl_valid_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      dl_data_q[0] <= in_word;
      dl_tag_q[0]  <= in_tag;
      for (int k = 1; k < PIPE_LAT; k++) begin
        dl_data_q[k] <= dl_data_q[k-1];
        dl_tag_q[k]  <= dl_tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_cntnew_q <= 1'b0;
      out_data_q   <= '0;
      acc_q        <= '0;
    end else if (i_Flush) begin
      out_valid_q  <= 1'b0;
      out_cntnew_q <= 1'b0;
    end else if (en) begin
      out_valid_q  <= dl_valid_q[LAST_STG];
      out_cntnew_q <= dl_valid_q[LAST_STG] & dl_tag_q[LAST_STG].last;
      if (dl_valid_q[LAST_STG]) begin
        out_data_q <= dl_data_q[LAST_STG];
        out_last_q <= dl_tag_q[LAST_STG].last;
        acc_q      <= (dl_tag_q[LAST_STG].first ? '0 : acc_q) + CNT_WIDTH'(pipe_sum);
      end
    end
  end

  assign o_Valid     = out_valid_q;
  assign o_Last      = out_last_q;
  assign o_CntNew    = out_cntnew_q;
  assign o_SubVector = out_data_q;
  assign o_Cnt       = acc_q;

endmodule

// File: tb/tb_cnt1_stream.sv
// Randomized scoreboard bench for cnt1_stream: driver pushes per-word and
// per-vector expectations, an independent monitor pops them at the output.
module tb_cnt1_stream;

  localparam int VW   = 920;
  localparam int BW   = 128;
  localparam int SVN  = 8;
  localparam int CW   = 10;
  localparam int LAT  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_Flush = 1'b0;
  logic [BW-1:0] i_Vector = '0;
  logic          i_Valid = 1'b0;
  logic          i_Ready = 1'b1;
  logic          o_Ready;
  logic [BW-1:0] o_SubVector;
  logic          o_Valid;
  logic          o_Last;
  logic [CW-1:0] o_Cnt;
  logic          o_CntNew;

  always #5 clk = ~clk;

  cnt1_stream dut (
    .clk         (clk),
    .rst         (rst),
    .i_Flush     (i_Flush),
    .i_Vector    (i_Vector),
    .i_Valid     (i_Valid),
    .o_Ready     (o_Ready),
    .o_SubVector (o_SubVector),
    .o_Valid     (o_Valid),
    .o_Last      (o_Last),
    .o_Cnt       (o_Cnt),
    .o_CntNew    (o_CntNew),
    .i_Ready     (i_Ready)
  );

  typedef struct {
    logic [BW-1:0] data;
    int            cnt;
    bit            last;
  } exp_t;

  exp_t          sb_q[$];
  int            wt_q[$];
  logic [BW-1:0] vec_w [SVN];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vec_idx  = 0;
  int run_cnt  = 0;
  int ready_pct = 100;
  bit ready_low = 1'b0;
  bit lat_arm   = 1'b0;
  int acc_cyc   = -1;
  int out_cyc   = -1;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #2;
    i_Ready = ready_low ? 1'b0 : ($urandom_range(99) < ready_pct);
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bits at absolute vector positions >= VW do not exist and must read as zero.
  function automatic logic [BW-1:0] ref_mask(input logic [BW-1:0] w, input int idx);
    logic [BW-1:0] r;
    r = w;
    for (int b = 0; b < BW; b++) if (idx * BW + b >= VW) r[b] = 1'b0;
    return r;
  endfunction

  function automatic int pop(input logic [BW-1:0] w);
    int n;
    n = 0;
    for (int b = 0; b < BW; b++) n += int'(w[b]);
    return n;
  endfunction

  task automatic push_expected(input logic [BW-1:0] w);
    exp_t e;
    e.data  = ref_mask(w, vec_idx);
    run_cnt = ((vec_idx == 0) ? 0 : run_cnt) + pop(e.data);
    e.cnt   = run_cnt;
    e.last  = (vec_idx == SVN - 1);
    sb_q.push_back(e);
    vec_idx = e.last ? 0 : vec_idx + 1;
  endtask

  // Called and returns at posedge+1.
  task automatic send_word(input logic [BW-1:0] w, input int maxgap);
    repeat ($urandom_range(maxgap)) begin
      i_Valid = 1'b0;
      @(posedge clk); #1;
    end
    i_Valid  = 1'b1;
    i_Vector = w;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (o_Ready) begin
        push_expected(w);
        if (lat_arm) begin
          acc_cyc = cyc;
          lat_arm = 1'b0;
        end
        break;
      end
      if (t > 200) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: o_Ready stayed 0 for %0d cycles, required 1", t);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_Valid = 1'b0;
  endtask

  task automatic make_vector(input int weight);
    int set;
    int p;
    for (int i = 0; i < SVN; i++) vec_w[i] = '0;
    set = 0;
    while (set < weight) begin
      p = $urandom_range(VW - 1);
      if (!vec_w[p / BW][p % BW]) begin
        vec_w[p / BW][p % BW] = 1'b1;
        set++;
      end
    end
    // Garbage above the tail must be masked away.
    for (int b = VW - (SVN - 1) * BW; b < BW; b++) vec_w[SVN-1][b] = 1'($urandom_range(1));
  endtask

  task automatic send_vector(input int weight, input int maxgap);
    wt_q.push_back(weight);
    for (int i = 0; i < SVN; i++) send_word(vec_w[i], maxgap);
  endtask

  task automatic drain();
    ready_low = 1'b0;
    i_Valid   = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending_words", sb_q.size(), 0);
    chk("drain_pending_vectors", wt_q.size(), 0);
  endtask

  // Output monitor: pops and compares on every downstream handshake.
  initial begin
    bit            prev_stall;
    bit            prev_rf;
    logic [BW-1:0] prev_data;
    logic [CW-1:0] prev_cnt;
    bit            prev_last;
    exp_t          e;
    int            w;
    prev_stall = 1'b0;
    prev_rf    = 1'b0;
    prev_data  = '0;
    prev_cnt   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_rf) begin
        chk("stall_valid", o_Valid, 1'b1);
        chk("stall_data", o_SubVector, prev_data);
        chk("stall_cnt", o_Cnt, prev_cnt);
        chk("stall_last", o_Last, prev_last);
      end
      if (o_Valid === 1'b1 && i_Ready === 1'b0 && rst === 1'b0) chk("stall_oready", o_Ready, 1'b0);
      if (o_Valid === 1'b1 || o_CntNew === 1'b1) chk("cntnew_is_valid_last", o_CntNew, o_Valid & o_Last);
      if (o_Valid === 1'b1 && acc_cyc >= 0 && out_cyc < 0) out_cyc = cyc;
      if (o_Valid === 1'b1 && i_Ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: o_Valid=1 data %0h cnt %0d, required no output", o_SubVector, o_Cnt);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", o_SubVector, e.data);
          chk("out_cnt", o_Cnt, e.cnt);
          chk("out_last", o_Last, e.last);
          $display("word data=%0h cnt=%0d last=%0b", o_SubVector, o_Cnt, o_Last);
          if (o_CntNew === 1'b1) begin
            if (wt_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_cntnew: got weight %0d, required none", o_Cnt);
            end else begin
              w = wt_q.pop_front();
              chk("vector_weight", o_Cnt, w);
            end
          end
        end
      end
      prev_stall = (o_Valid === 1'b1) && (i_Ready === 1'b0);
      prev_rf    = (rst === 1'b1) || (i_Flush === 1'b1);
      prev_data  = o_SubVector;
      prev_cnt   = o_Cnt;
      prev_last  = o_Last;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_oready_in_rst", o_Ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", o_Valid, 1'b0);
    chk("reset_cnt", o_Cnt, 0);
    chk("reset_last", o_Last, 1'b0);
    chk("reset_cntnew", o_CntNew, 1'b0);
    chk("reset_data", o_SubVector, 0);
    chk("reset_oready", o_Ready, 1'b1);
    @(posedge clk); #1;

    // All-ones vector: running counts 128..896, 920 and fixed latency.
    ready_pct = 100;
    for (int i = 0; i < SVN; i++) vec_w[i] = '1;
    lat_arm = 1'b1;
    send_vector(VW, 0);
    drain();
    chk("latency", out_cyc - acc_cyc, LAT);

    // Only the tail word set: exactly the tail bits are counted.
    for (int i = 0; i < SVN; i++) vec_w[i] = '0;
    vec_w[SVN-1] = '1;
    send_vector(VW - (SVN - 1) * BW, 0);
    drain();

    // Back-to-back vectors with input gaps and random downstream ready.
    ready_pct = 70;
    make_vector(37);
    send_vector(37, 3);
    make_vector(512);
    send_vector(512, 3);
    drain();

    // Downstream stall for 10 cycles with the pipeline full.
    ready_pct = 100;
    make_vector($urandom_range(1, VW));
    wt_q.push_back(pop(vec_w[0]) + pop(vec_w[1]) + pop(vec_w[2]) + pop(vec_w[3]) +
                   pop(vec_w[4]) + pop(vec_w[5]) + pop(vec_w[6]) + pop(ref_mask(vec_w[7], 7)));
    for (int i = 0; i < 5; i++) send_word(vec_w[i], 0);
    ready_low = 1'b1;
    i_Valid   = 1'b1;
    i_Vector  = vec_w[5];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold_oready", o_Ready, 1'b0);
      @(posedge clk); #1;
    end
    ready_low = 1'b0;
    for (int i = 5; i < SVN; i++) send_word(vec_w[i], 0);
    drain();

    // Flush after three words, then a fresh vector of weight 100.
    make_vector(300);
    for (int i = 0; i < 3; i++) send_word(vec_w[i], 0);
    i_Flush = 1'b1;
    @(negedge clk);
    chk("flush_oready", o_Ready, 1'b0);
    @(posedge clk); #1;
    i_Flush = 1'b0;
    sb_q.delete();
    vec_idx = 0;
    @(negedge clk);
    chk("flush_valid", o_Valid, 1'b0);
    @(posedge clk); #1;
    make_vector(100);
    send_vector(100, 1);
    drain();

    // Reset while stalled mid-vector.
    make_vector(400);
    for (int i = 0; i < 5; i++) send_word(vec_w[i], 0);
    ready_low = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall_oready", o_Ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    wt_q.delete();
    vec_idx   = 0;
    ready_low = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", o_Valid, 1'b0);
    chk("rst_mid_cnt", o_Cnt, 0);
    chk("rst_mid_oready", o_Ready, 1'b1);
    @(posedge clk); #1;
    make_vector(250);
    send_vector(250, 1);
    drain();

    // Random vectors under random backpressure.
    for (int v = 0; v < 5; v++) begin
      int wgt;
      ready_pct = $urandom_range(50, 100);
      wgt = $urandom_range(0, VW);
      make_vector(wgt);
      send_vector(wgt, 2);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
